// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution window reader.
// Pure elaboration-time arithmetic; nothing here becomes runtime logic.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

  function automatic int taps(input int k);
    return k * k;
  endfunction

  function automatic int beats(input int k, input int ports);
    return (k * k + ports - 1) / ports;
  endfunction

  function automatic int off(input int t, input int k, input int img_w);
    return (t / k) * img_w + (t % k);
  endfunction

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_tap_offset_rom.sv
// Constant tap-offset table: beat index -> packed per-port offsets
// and the lane mask for that beat.
module conv_tap_offset_rom
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int RAM_PORTS  = 2,
  parameter int K          = 3,
  parameter int IMG_W      = 252,
  parameter int BW         = 3
) (
  input  logic [BW-1:0]                   i_beat,
  output logic [ADDR_WIDTH*RAM_PORTS-1:0] o_offs,
  output logic [RAM_PORTS-1:0]            o_mask
);

  localparam int TAPS  = taps(K);
  localparam int BEATS = beats(K, RAM_PORTS);

  logic [BEATS-1:0][RAM_PORTS-1:0][ADDR_WIDTH-1:0] w_tab;
  logic [BEATS-1:0][RAM_PORTS-1:0]                 w_msk;

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    for (genvar p = 0; p < RAM_PORTS; p++) begin : g_port
      localparam int T = b * RAM_PORTS + p;
      if (T < TAPS) begin : g_on
        assign w_tab[b][p] = ADDR_WIDTH'(off(T, K, IMG_W));
        assign w_msk[b][p] = 1'b1;
      end else begin : g_off
        assign w_tab[b][p] = '0;
        assign w_msk[b][p] = 1'b0;
      end
    end
  end

  always_comb begin
    o_offs = '0;
    o_mask = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (i_beat == BW'(b)) begin
        o_offs = w_tab[b];
        o_mask = w_msk[b];
      end
    end
  end

endmodule

// File: rtl/conv_window_reader.sv
// Sweeps every stride-1 KxK window of a feature map, issuing tap
// addresses to the BRAM and tagging the returned beats.
module conv_window_reader
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_PORTS  = 2,
  parameter int IMG_W      = 252,
  parameter int IMG_H      = 252,
  parameter int K          = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_start,
  input  logic [ADDR_WIDTH-1:0]           i_base_addr,
  input  logic                            i_ready,
  output logic [ADDR_WIDTH*RAM_PORTS-1:0] o_r_addrs,
  output logic [RAM_PORTS-1:0]            o_port_mask,
  output logic                            o_data_valid,
  output logic                            o_win_first,
  output logic                            o_win_last,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int OUT_W = out_dim(IMG_W, K);
  localparam int OUT_H = out_dim(IMG_H, K);
  localparam int BEATS = beats(K, RAM_PORTS);
  localparam int BW    = cw(BEATS);
  localparam int XW    = cw(OUT_W);
  localparam int YW    = cw(OUT_H);
  localparam int AW    = ADDR_WIDTH;
  localparam int NW    = ADDR_WIDTH * RAM_PORTS;

  if (K < 1 || K > IMG_W || K > IMG_H ||
      RAM_PORTS < 1 || RAM_PORTS > K * K ||
      RAM_WIDTH < 1) begin : g_bad_cfg
    $error("conv_window_reader: bad parameters");
  end

  state_t r_state;
  state_t w_state_nxt;

  logic [XW-1:0] r_ox;
  logic [YW-1:0] r_oy;
  logic [BW-1:0] r_beat;
  logic [AW-1:0] r_wb;

  logic [NW-1:0]        r_addrs;
  logic [RAM_PORTS-1:0] r_pmask;
  logic                 r_pvalid;
  logic                 r_pfirst;
  logic                 r_plast;

  logic                 r_dv;
  logic [RAM_PORTS-1:0] r_dmask;
  logic                 r_dfirst;
  logic                 r_dlast;
  logic                 r_done;

  logic                 w_adv;
  logic                 w_last_b;
  logic                 w_last_x;
  logic                 w_last_y;
  logic                 w_final;
  logic                 w_load;
  logic                 w_step;
  logic                 w_flush;
  logic [BW-1:0]        w_nxt_beat;
  logic [XW-1:0]        w_nxt_ox;
  logic [YW-1:0]        w_nxt_oy;
  logic [AW-1:0]        w_nxt_wb;
  logic [BW-1:0]        w_src_beat;
  logic [XW-1:0]        w_src_ox;
  logic [YW-1:0]        w_src_oy;
  logic [AW-1:0]        w_src_wb;
  logic [NW-1:0]        w_offs;
  logic [RAM_PORTS-1:0] w_mask;
  logic [NW-1:0]        w_iss;

  assign w_adv    = i_ready | ~r_dv;
  assign w_last_b = (r_beat == BW'(BEATS - 1));
  assign w_last_x = (r_ox == XW'(OUT_W - 1));
  assign w_last_y = (r_oy == YW'(OUT_H - 1));
  assign w_final  = w_last_b & w_last_x & w_last_y;

  // Window base moves by +1 per column and +K across a row wrap.
  always_comb begin
    w_nxt_beat = r_beat + BW'(1);
    w_nxt_ox   = r_ox;
    w_nxt_oy   = r_oy;
    w_nxt_wb   = r_wb;
    if (w_last_b) begin
      w_nxt_beat = '0;
      if (w_last_x) begin
        w_nxt_ox = '0;
        w_nxt_oy = r_oy + YW'(1);
        w_nxt_wb = r_wb + AW'(K);
      end else begin
        w_nxt_ox = r_ox + XW'(1);
        w_nxt_wb = r_wb + AW'(1);
      end
    end
  end

  always_comb begin
    w_src_beat = w_nxt_beat;
    w_src_ox   = w_nxt_ox;
    w_src_oy   = w_nxt_oy;
    w_src_wb   = w_nxt_wb;
    if (r_state == S_IDLE) begin
      w_src_beat = '0;
      w_src_ox   = '0;
      w_src_oy   = '0;
      w_src_wb   = i_base_addr;
    end
  end

  conv_tap_offset_rom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_PORTS  (RAM_PORTS),
    .K          (K),
    .IMG_W      (IMG_W),
    .BW         (BW)
  ) u_rom (
    .i_beat (w_src_beat),
    .o_offs (w_offs),
    .o_mask (w_mask)
  );

  always_comb begin
    w_iss = '0;
    for (int p = 0; p < RAM_PORTS; p++) begin
      if (w_mask[p]) begin
        w_iss[AW*p +: AW] = w_src_wb + w_offs[AW*p +: AW];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_adv && w_final) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_adv) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_flush = 1'b0;
    o_busy  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_load = i_start;
      end
      S_RUN: begin
        o_busy  = 1'b1;
        w_step  = w_adv & ~w_final;
        w_flush = w_adv & w_final;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ox     <= '0;
      r_oy     <= '0;
      r_beat   <= '0;
      r_wb     <= '0;
      r_addrs  <= '0;
      r_pmask  <= '0;
      r_pvalid <= 1'b0;
      r_pfirst <= 1'b0;
      r_plast  <= 1'b0;
    end else begin
      unique case (1'b1)
        (w_load | w_step): begin
          r_ox     <= w_src_ox;
          r_oy     <= w_src_oy;
          r_beat   <= w_src_beat;
          r_wb     <= w_src_wb;
          r_addrs  <= w_iss;
          r_pmask  <= w_mask;
          r_pvalid <= 1'b1;
          r_pfirst <= (w_src_beat == '0);
          r_plast  <= (w_src_beat == BW'(BEATS - 1));
        end
        w_flush: begin
          r_ox     <= '0;
          r_oy     <= '0;
          r_beat   <= '0;
          r_addrs  <= '0;
          r_pmask  <= '0;
          r_pvalid <= 1'b0;
          r_pfirst <= 1'b0;
          r_plast  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Data stage mirrors the issue stage one cycle later, matching
  // the BRAM read latency.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dv     <= 1'b0;
      r_dmask  <= '0;
      r_dfirst <= 1'b0;
      r_dlast  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_adv) begin
        r_dv     <= r_pvalid;
        r_dmask  <= r_pmask;
        r_dfirst <= r_pfirst;
        r_dlast  <= r_plast;
      end
      r_done <= (r_state == S_DRAIN) & w_adv;
    end
  end

  assign o_r_addrs    = r_addrs;
  assign o_port_mask  = r_dmask;
  assign o_data_valid = r_dv;
  assign o_win_first  = r_dfirst;
  assign o_win_last   = r_dlast;
  assign o_done       = r_done;

endmodule

// File: tb/tb_conv_window_reader.sv
// Bench for conv_window_reader: four configurations driven in
// parallel, each checked against a window-enumeration model.
module tb_conv_window_reader;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          ready;
  logic [AW-1:0] base;

  logic [AW*2-1:0] a_addrs;
  logic [1:0]      a_mask;
  logic            a_dv, a_first, a_last, a_busy, a_done;
  logic [AW*4-1:0] b_addrs;
  logic [3:0]      b_mask;
  logic            b_dv, b_first, b_last, b_busy, b_done;
  logic [AW*9-1:0] c_addrs;
  logic [8:0]      c_mask;
  logic            c_dv, c_first, c_last, c_busy, c_done;
  logic [AW*2-1:0] d_addrs;
  logic [1:0]      d_mask;
  logic            d_dv, d_first, d_last, d_busy, d_done;

  always #5 clk = ~clk;

  conv_window_reader #(
    .ADDR_WIDTH(AW), .RAM_WIDTH(8), .RAM_PORTS(2),
    .IMG_W(5), .IMG_H(4), .K(3)
  ) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_base_addr(base), .i_ready(ready),
    .o_r_addrs(a_addrs), .o_port_mask(a_mask),
    .o_data_valid(a_dv), .o_win_first(a_first),
    .o_win_last(a_last), .o_busy(a_busy), .o_done(a_done)
  );

  conv_window_reader #(
    .ADDR_WIDTH(AW), .RAM_WIDTH(8), .RAM_PORTS(4),
    .IMG_W(5), .IMG_H(4), .K(3)
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_base_addr(base), .i_ready(ready),
    .o_r_addrs(b_addrs), .o_port_mask(b_mask),
    .o_data_valid(b_dv), .o_win_first(b_first),
    .o_win_last(b_last), .o_busy(b_busy), .o_done(b_done)
  );

  conv_window_reader #(
    .ADDR_WIDTH(AW), .RAM_WIDTH(8), .RAM_PORTS(9),
    .IMG_W(5), .IMG_H(4), .K(3)
  ) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_base_addr(base), .i_ready(ready),
    .o_r_addrs(c_addrs), .o_port_mask(c_mask),
    .o_data_valid(c_dv), .o_win_first(c_first),
    .o_win_last(c_last), .o_busy(c_busy), .o_done(c_done)
  );

  conv_window_reader #(
    .ADDR_WIDTH(AW), .RAM_WIDTH(8), .RAM_PORTS(2),
    .IMG_W(3), .IMG_H(3), .K(3)
  ) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_base_addr(base), .i_ready(ready),
    .o_r_addrs(d_addrs), .o_port_mask(d_mask),
    .o_data_valid(d_dv), .o_win_first(d_first),
    .o_win_last(d_last), .o_busy(d_busy), .o_done(d_done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int act[4], iss[4], dat[4], base_l[4];
  int busy_cyc[4], acc[4], donec[4];
  bit exp_done[4];
  bit prv_rst = 1'b0;

  logic [AW*2-1:0] logA_addr[30];
  logic [3:0]      logA_q[30];

  typedef struct {
    int              n;
    logic [AW*2-1:0] addrs;
    logic [1:0]      mask;
    bit              first;
    bit              last;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input int i, input string nm,
                     input logic [255:0] got,
                     input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h want %h", nm, i, got, want);
    end
  endtask

  // Expected address for global beat n, port p, from window geometry.
  function automatic logic [AW-1:0] m_addr(input int bs, W, H, K, P,
                                           input int n, p);
    int nb, ow, win, b, ox, oy, t;
    nb  = (K * K + P - 1) / P;
    ow  = W - K + 1;
    win = n / nb;
    b   = n % nb;
    ox  = win % ow;
    oy  = win / ow;
    t   = b * P + p;
    if (t >= K * K) return '0;
    return AW'((bs + (oy + t / K) * W + ox + t % K) % (1 << AW));
  endfunction

  task automatic mon(input int i, W, H, K, P,
                     input logic [152:0] ad, input logic [8:0] mk,
                     input logic dv, fi, la, bz, dn);
    int nb, total, b;
    logic [152:0] ea;
    logic [8:0] em;
    bit edv, adv, was;
    nb    = (K * K + P - 1) / P;
    total = (W - K + 1) * (H - K + 1) * nb;
    edv   = 1'b0;
    if (!prv_rst) begin
      chk(i, "reset_outputs",
          256'({ad, mk, dv, fi, la, bz, dn}), 256'(0));
      act[i] = 0;
      exp_done[i] = 1'b0;
      iss[i] = 0;
      dat[i] = 0;
    end else begin
      chk(i, "busy", 256'(bz), 256'(act[i] != 0));
      chk(i, "done", 256'(dn), 256'(exp_done[i]));
      if (exp_done[i] && dn) donec[i]++;
      edv = (act[i] != 0) && (iss[i] > dat[i]);
      chk(i, "data_valid", 256'(dv), 256'(edv));
      if (act[i] != 0 && iss[i] < total) begin
        ea = '0;
        for (int p = 0; p < P; p++)
          ea[AW*p +: AW] = m_addr(base_l[i], W, H, K, P, iss[i], p);
        chk(i, "r_addrs", 256'(ad), 256'(ea));
        if (i == 0) logA_addr[iss[i]] = ad[AW*2-1:0];
      end
      if (edv) begin
        b  = dat[i] % nb;
        em = '0;
        for (int p = 0; p < P; p++) em[p] = (b * P + p < K * K);
        chk(i, "mask_first_last", 256'({mk, fi, la}),
            256'({em, b == 0, b == nb - 1}));
        if (i == 0) logA_q[dat[i]] = {mk[1:0], fi, la};
      end
      if (act[i] != 0) busy_cyc[i]++;
    end
    was = (act[i] != 0);
    exp_done[i] = 1'b0;
    if (was) begin
      adv = ready | ~edv;
      if (adv && iss[i] < total) iss[i]++;
      if (edv && ready) begin
        dat[i]++;
        acc[i]++;
        if (dat[i] == total) begin
          act[i] = 0;
          exp_done[i] = 1'b1;
        end
      end
    end
    if (!was && start && rst_n) begin
      act[i]      = 1;
      iss[i]      = 0;
      dat[i]      = 0;
      base_l[i]   = int'(base);
      busy_cyc[i] = 0;
      acc[i]      = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, 5, 4, 3, 2, 153'(a_addrs), 9'(a_mask),
        a_dv, a_first, a_last, a_busy, a_done);
    mon(1, 5, 4, 3, 4, 153'(b_addrs), 9'(b_mask),
        b_dv, b_first, b_last, b_busy, b_done);
    mon(2, 5, 4, 3, 9, c_addrs, c_mask,
        c_dv, c_first, c_last, c_busy, c_done);
    mon(3, 3, 3, 3, 2, 153'(d_addrs), 9'(d_mask),
        d_dv, d_first, d_last, d_busy, d_done);
    prv_rst = rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_idle();
    return act[0] == 0 && act[1] == 0 && act[2] == 0 && act[3] == 0;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    for (int c = 0; c < budget; c++) begin
      tick();
      if (all_idle()) begin
        repeat (2) tick();
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout after %0d cycles", nm, budget);
  endtask

  task automatic wait_dat(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (dat[0] == n) return;
      tick();
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_beat: beat %0d never reached", n);
  endtask

  task automatic pulse_start(input logic [AW-1:0] bs);
    base  = bs;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int d0;
    tbl[0] = '{0,  {17'd101, 17'd100}, 2'b11, 1'b1, 1'b0};
    tbl[1] = '{2,  {17'd107, 17'd106}, 2'b11, 1'b0, 1'b0};
    tbl[2] = '{4,  {17'd0,   17'd112}, 2'b01, 1'b0, 1'b1};
    tbl[3] = '{5,  {17'd102, 17'd101}, 2'b11, 1'b1, 1'b0};
    tbl[4] = '{15, {17'd106, 17'd105}, 2'b11, 1'b1, 1'b0};
    tbl[5] = '{29, {17'd0,   17'd119}, 2'b01, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    base  = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Free-running sweep with the reference geometry.
    pulse_start(17'd100);
    wait_idle("free_run", 200);
    chk(0, "beats_accepted", 256'(acc[0]), 256'(30));
    chk(0, "busy_cycles", 256'(busy_cyc[0]), 256'(31));
    for (int k = 0; k < 6; k++) begin
      chk(tbl[k].n, "tbl_addrs",
          256'(logA_addr[tbl[k].n]), 256'(tbl[k].addrs));
      chk(tbl[k].n, "tbl_quals", 256'(logA_q[tbl[k].n]),
          256'({tbl[k].mask, tbl[k].first, tbl[k].last}));
    end

    // Three-cycle backpressure on beat 7.
    pulse_start(17'd100);
    wait_dat(7, 50);
    ready = 1'b0;
    repeat (3) tick();
    ready = 1'b1;
    wait_idle("stall", 200);
    chk(0, "stall_busy_cycles", 256'(busy_cyc[0]), 256'(34));
    chk(0, "stall_beats", 256'(acc[0]), 256'(30));

    // Reset mid-sweep, then replay.
    pulse_start(17'd100);
    wait_dat(12, 50);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    pulse_start(17'd100);
    wait_idle("after_reset", 200);
    chk(0, "replay_beats", 256'(acc[0]), 256'(30));

    // Start held high: back-to-back sweeps.
    d0    = donec[0];
    base  = 17'd200;
    start = 1'b1;
    for (int c = 0; c < 300 && donec[0] < d0 + 2; c++) tick();
    start = 1'b0;
    chk(0, "held_start_sweeps", 256'(donec[0] - d0), 256'(2));
    wait_idle("held_start", 200);

    // Start pulse during RUN is ignored.
    pulse_start(17'd300);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("start_in_run", 200);
    chk(0, "run_start_beats", 256'(acc[0]), 256'(30));

    // Random bases and random backpressure.
    for (int r = 0; r < 8; r++) begin
      pulse_start(AW'($urandom_range(0, 131000)));
      for (int c = 0; c < 400 && !all_idle(); c++) begin
        ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      ready = 1'b1;
      wait_idle("random", 200);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_reader.md
# conv_window_reader

Read-side scheduler for the multi-port feature-map BRAM in the convolution datapath. On a start command it sweeps every stride-1 KxK window of an IMG_W x IMG_H row-major feature map. Each cycle it issues up to RAM_PORTS tap addresses on the BRAM read ports. It tags the returned 1-cycle-latency read data with valid/port-mask/first/last qualifiers for the MAC array, with downstream backpressure.

## Interface
- ADDR_WIDTH, 17: BRAM address width.
- RAM_WIDTH, 8: pixel width; qualifiers only, data does not pass through this block.
- RAM_PORTS, 2: BRAM read ports driven in parallel, 1..K*K.
- IMG_W, 252: feature-map width in pixels.
- IMG_H, 252: feature-map height in pixels.
- K, 3: square kernel size; K <= IMG_W, K <= IMG_H.
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  start sweep; sampled only in IDLE.
- i_base_addr  in  ADDR_WIDTH  address of pixel (0,0); latched on accepted start.
- i_ready  in  1  downstream accepts current data beat.
- o_r_addrs  out  ADDR_WIDTH*RAM_PORTS  packed read addresses, port p at bits [ADDR_WIDTH*p +: ADDR_WIDTH]; to BRAM i_r_addrs.
- o_port_mask  out  RAM_PORTS  per-port validity of the current data beat; bit p qualifies BRAM o_data lane p.
- o_data_valid  out  1  BRAM o_data holds a beat this cycle.
- o_win_first  out  1  beat is first of its window.
- o_win_last  out  1  beat is last of its window.
- o_busy  out  1  sweep in progress.
- o_done  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- Derived constants:
  - OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1.
  - TAPS = K*K.
  - BEATS = ceil(TAPS/RAM_PORTS).
- Tap order t = ky*K+kx, row-major. Tap offset off[t] = ky*IMG_W+kx, elaboration-time constant.
- Window base: wb = base + oy*IMG_W + ox, updated incrementally.
  - Next column: +1.
  - Row wrap: +K.
  - No runtime multiply or divide.
- Beat b drives port p with tap t = b*RAM_PORTS+p.
  - If t < TAPS: address wb+off[t], mask bit 1.
  - Else: address 0, mask bit 0.
- Window order: ox fastest, then oy.
- FSM states:
  - IDLE: outputs quiet. i_start -> RUN; latch base; clear oy, ox, b.
  - RUN: issue one beat per advance. After beat BEATS-1 of window (OUT_H-1, OUT_W-1) -> DRAIN.
  - DRAIN: wait for the final beat to be accepted -> IDLE, pulse o_done.
- Two stages:
  - Issue stage: registered o_r_addrs plus pending qualifiers.
  - Data stage: o_data_valid, o_port_mask, o_win_first, o_win_last, aligned with BRAM output.
- Advance enable: adv = i_ready | ~o_data_valid. When adv is low, hold addresses and all qualifiers. BRAM re-reads the same addresses, so o_data stays stable.
- Address arithmetic is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH. The caller guarantees base+IMG_W*IMG_H <= 2^ADDR_WIDTH.
- i_start during RUN or DRAIN is ignored.

## Timing
- Reset (i_rst_n low at an edge): state IDLE; all counters 0; o_r_addrs 0; o_port_mask 0; o_data_valid, o_win_first, o_win_last, o_busy, o_done all 0. Reset mid-sweep aborts with no o_done.
- Start accepted at edge E0. o_busy is 1 from E0.
  - First addresses appear after E0.
  - First o_data_valid appears after E0+1.
- With i_ready held high, one beat per cycle. Total beats = OUT_W*OUT_H*BEATS. No bubbles between windows or rows.
- o_done asserts for one cycle after the edge at which the final beat is accepted. o_busy falls on that same edge.
- The earliest new start is the cycle o_done is high, since the state is already IDLE.

## Structure
- Shared package conv_pkg: OUT_W/OUT_H/TAPS/BEATS computation functions and the tap-offset function off(t, K, IMG_W).
- One sub-module, conv_tap_offset_rom: combinational constant table, beat index -> RAM_PORTS packed offsets plus mask.

## Test plan
- IMG_W=5, IMG_H=4, K=3, RAM_PORTS=2, base=100, i_ready=1:
  - 30 beats.
  - Beat0 addrs {100,101} mask 11, first=1.
  - Beat4 addrs {112,0} mask 01, last=1.
  - Beat5 port0 address 101.
  - Final beat port0 address 119.
  - o_done one cycle after beat 29.
- Same config, i_ready low for 3 cycles on beat 7: o_r_addrs, mask and flags held. Sequence is identical to the free-running case, 3 cycles longer.
- RAM_PORTS=4: 3 beats per window, last beat mask 0001. RAM_PORTS=9: one beat per window, mask all-ones, first=last=1.
- i_rst_n low for one cycle at beat 12:
  - All outputs 0 next cycle, no o_done.
  - A subsequent start replays from base correctly.
- i_start held high throughout: second sweep begins only after o_done. A start pulse during RUN is ignored.
- Degenerate K=IMG_W=IMG_H=3, RAM_PORTS=2: single window, 5 beats, addresses base..base+8 in order.
